// File: rtl/summation_inverse.sv
// summation_inverse: finds the largest n with 1+2+..+n <= S
// by repeated subtraction, reporting n and the leftover.
module summation_inverse #(
  parameter int W  = 8,
  parameter int NW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  sum_in,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] n_out,
  output logic [W-1:0]  rem_out,
  output logic          exact
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [W-1:0]  rem_q;
  logic [NW-1:0] k_q;
  logic [NW-1:0] n_q;
  logic          exact_q;
  logic [W-1:0]  k_ext;
  logic          ge;

  assign k_ext = {{(W-NW){1'b0}}, k_q};
  assign ge    = (rem_q >= k_ext);

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state: subtract until the next step no longer fits
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == IDLE): if (start) state_d = SUB;
      (state_q == SUB):  if (!ge) state_d = DONE;
      (state_q == DONE): state_d = IDLE;
      default:           state_d = IDLE;
    endcase
  end

  // handshake outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (1'b1)
      (state_q == SUB):  busy = 1'b1;
      (state_q == DONE): done = 1'b1;
      default: ;
    endcase
  end

  // datapath: remainder, step, count and exact flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q   <= '0;
      k_q     <= '0;
      n_q     <= '0;
      exact_q <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        rem_q   <= sum_in;
        k_q     <= NW'(1);
        n_q     <= '0;
        exact_q <= 1'b0;
      end else if (state_q == SUB) begin
        if (ge) begin
          rem_q <= rem_q - k_ext;
          n_q   <= n_q + NW'(1);
          k_q   <= k_q + NW'(1);
        end else begin
          exact_q <= (rem_q == '0);
        end
      end
    end
  end

  assign n_out   = n_q;
  assign rem_out = rem_q;
  assign exact   = exact_q;

endmodule

// File: tb/tb_summation_inverse.sv
// tb_summation_inverse: directed vectors, expected results
// queued by the driver and checked by a done-triggered monitor.
`timescale 1ns/1ps
module tb_summation_inverse;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] sum_in;
  logic       busy;
  logic       done;
  logic [4:0] n_out;
  logic [7:0] rem_out;
  logic       exact;

  typedef struct {
    int s;
    int n;
    int rem;
    int ex;
    int lat;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  summation_inverse #(.W(8), .NW(5)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .sum_in(sum_in),
    .busy(busy),
    .done(done),
    .n_out(n_out),
    .rem_out(rem_out),
    .exact(exact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic push(input int s, input int n, input int rem,
                      input int ex);
    exp_t e;
    e.s = s;
    e.n = n;
    e.rem = rem;
    e.ex = ex;
    e.lat = n + 2;
    q.push_back(e);
  endtask

  task automatic wait_done(input string name);
    int i;
    for (i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) break;
    end
    if (i == 40) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic run(input int s, input int n, input int rem,
                     input int ex);
    @(negedge clk);
    sum_in = 8'(s);
    start = 1'b1;
    push(s, n, rem, ex);
    @(negedge clk);
    start = 1'b0;
    sum_in = 8'hA5;
    wait_done($sformatf("s%0d", s));
  endtask

  // monitor: latency and busy-length tracking, compare on done
  int  cyc = 0;
  int  bcnt = 0;
  logic busy_q = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (busy && !busy_q) begin
      cyc = 1;
      bcnt = 1;
    end else begin
      if (busy || done) cyc++;
      if (busy) bcnt++;
    end
    busy_q = busy;
    if (done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        chk($sformatf("s%0d_n", e.s), int'(n_out), e.n);
        chk($sformatf("s%0d_rem", e.s), int'(rem_out), e.rem);
        chk($sformatf("s%0d_exact", e.s), int'(exact), e.ex);
        chk($sformatf("s%0d_latency", e.s), cyc, e.lat);
        chk($sformatf("s%0d_busy_len", e.s), bcnt, e.n + 1);
        chk($sformatf("s%0d_busy_at_done", e.s), int'(busy), 0);
      end
    end
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    sum_in = 8'd0;
    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_n", int'(n_out), 0);
    chk("rst_rem", int'(rem_out), 0);
    chk("rst_exact", int'(exact), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_outs", int'({busy, done, exact}) + int'(n_out)
          + int'(rem_out), 0);
    end

    run(0, 0, 0, 1);
    run(10, 4, 0, 1);
    run(11, 4, 1, 0);
    run(253, 22, 0, 1);
    run(255, 22, 2, 0);

    // start re-pulsed mid-SUB and held through DONE, then restart
    @(negedge clk);
    sum_in = 8'd100;
    start = 1'b1;
    push(100, 13, 9, 0);
    @(negedge clk);
    start = 1'b0;
    sum_in = 8'd55;
    repeat (4) @(negedge clk);
    start = 1'b1;
    wait_done("s100");
    sum_in = 8'd3;
    push(3, 2, 0, 1);
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done("s3");

    // asynchronous abort mid-SUB
    @(negedge clk);
    sum_in = 8'd200;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_n", int'(n_out), 0);
    chk("abort_rem", int'(rem_out), 0);
    chk("abort_exact", int'(exact), 0);
    #2;
    reset = 1'b1;
    repeat (30) @(negedge clk);
    chk("abort_idle_busy", int'(busy), 0);
    run(6, 3, 0, 1);

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/summation_inverse.md
# summation_inverse

Iterative FSMD that inverts the summation datapath: given an 8-bit sum S, it finds the largest n with 1+2+…+n ≤ S and reports the leftover. It works by repeated subtraction of 1, 2, 3, … and exposes a start/busy/done handshake. It sits downstream of the summation block and checks or decodes its `out` value. It shares that block's 8-bit data width and its `reset` naming.

## Interface
- `W`, 8: width of the sum input and remainder output.
- `NW`, 5: width of the count output and internal step counter. Must hold floor((sqrt(8·(2^W−1)+1)−1)/2)+1; for W=8 that is 22+1 = 23.
- `clk` input 1: single clock; all registers update on the rising edge.
- `reset` input 1: asynchronous, active-low. Low forces all state and outputs to reset values immediately, independent of `clk`.
- `start` input 1: request; sampled only in IDLE.
- `sum_in` input W: sum S; captured on the edge that accepts `start`.
- `busy` output 1: high while in SUB.
- `done` output 1: one-cycle pulse in DONE.
- `n_out` output NW: largest n with n(n+1)/2 ≤ S.
- `rem_out` output W: S − n(n+1)/2.
- `exact` output 1: high when `rem_out` == 0, i.e. S is triangular.

## Operation
- Registers: `state`, `rem` (W bits), `k` (NW bits, next subtrahend), `n` (NW bits). `n_out`/`rem_out` are driven from `n`/`rem`.
- `exact` is registered and updated on entry to DONE.
- Reset values: state = IDLE, `busy` = 0, `done` = 0, `n_out` = 0, `rem_out` = 0, `exact` = 0, `k` = 0.
- IDLE:
  - `start` = 1: `rem` ← `sum_in`, `k` ← 1, `n` ← 0, `exact` ← 0; go to SUB.
  - `start` = 0: hold all registers.
- SUB:
  - Compare `rem` ≥ `k`, with `k` zero-extended to W bits.
  - True: `rem` ← `rem` − `k`, `n` ← `n`+1, `k` ← `k`+1; stay in SUB.
  - False: `rem`/`n`/`k` unchanged; `exact` ← (`rem` == 0); go to DONE.
- DONE: `done` = 1 for exactly this cycle; go to IDLE unconditionally.
- `start` is ignored in SUB and DONE; no queuing.
- Results hold from DONE until the next accepted `start`.
- The subtraction never underflows because it only executes when `rem` ≥ `k`.
- `k` never exceeds n+1 ≤ 23, so no wrap occurs for W=8, NW=5.

## Timing
- Let edge E0 be the edge that samples `start` = 1 in IDLE.
- SUB occupies n+1 cycles: n subtracting cycles plus one terminating compare.
- `done` is high in the cycle after edge E0+n+1, i.e. n+2 cycles after E0.
- Latency bounds: S=0 gives 2 cycles; S=255 gives 24 cycles.
- `busy` rises on E0 and falls on the edge entering DONE; `busy` and `done` are never high together.
- `n_out`/`rem_out` change only during SUB; their values while `busy` = 1 are intermediate and not valid.
- After the DONE cycle the block is in IDLE, so the earliest back-to-back restart is sampled on the edge after `done`.
- `reset` low at any time, including mid-SUB or during DONE, aborts the computation. All outputs go to reset values with no `done` pulse. After release, the first edge sees IDLE.
- `sum_in` changes after E0 have no effect on the current computation.

## Test plan
- Reset low, then release with `start` = 0 → all outputs stay 0 and the block stays in IDLE indefinitely.
- S=0 → `done` at E0+2; `n_out`=0, `rem_out`=0, `exact`=1; `busy` high for exactly 1 cycle.
- S=10 → `done` at E0+6; `n_out`=4, `rem_out`=0, `exact`=1. S=11 → `n_out`=4, `rem_out`=1, `exact`=0.
- S=253 → `n_out`=22, `rem_out`=0, `exact`=1. S=255 → `n_out`=22, `rem_out`=2, `exact`=0, `done` at E0+24.
- S=100 with `start` pulsed again mid-SUB and held through DONE → second pulse ignored; `n_out`=13, `rem_out`=9. A `start` with S=3 on the edge after `done` → `n_out`=2, `rem_out`=0.
- S=200, `reset` driven low for 3 ns between edges mid-SUB → all outputs read 0 before the next edge and no `done` pulse. Restart with S=6 → `n_out`=3, `exact`=1.
